game_progress: RTL

- Upstream of the score stage. Turns raw collision levels from the hit-detection logic into the single-cycle event pulses the score stage consumes: monster_died_pulse, boss_died_pulse, asteroid_exploded_pulse.
- Also owns game progression: stage_num, lives, boss phase, game_over and win.
- One instance per game, in the top-level game-control area.

---
 rtl/game_progress_pkg.sv | 18 +
 rtl/game_progress_edge_pulse.sv | 21 ++
 rtl/game_progress.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/game_progress_pkg.sv
// Shared types and widths for the game progression block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_progress_pkg;

  localparam int STAGE_W = 3;
  localparam int LIVES_W = 3;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAY        = 3'd1,
    STAGE_CLEAR = 3'd2,
    BOSS        = 3'd3,
    GAME_OVER   = 3'd4,
    WIN         = 3'd5
  } state_t;

endpackage

// File: rtl/game_progress_edge_pulse.sv
// Rising-edge detector: one history flop, output = level & ~previous level.
// Latency: output is combinational in the first cycle the level is seen high.
// Backpressure: none; the level is sampled every cycle.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // remember last cycle's level so only the first high cycle fires
  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/game_progress.sv
// Turns collision levels into score-stage event pulses and runs stage/lives/boss progression.
// Latency: pulses are combinational from the first high cycle of a collision; state updates on the next clock.
// Backpressure: none; every edge is consumed in the cycle it occurs. Build option: GAME_PROGRESS_EXTRA_LIFE_EN.
module game_progress
  import game_progress_pkg::*;
#(
  parameter int MONSTERS_PER_STAGE = 24,
  parameter int MAX_STAGE          = 5,
  parameter int BOSS_HP            = 8,
  parameter int START_LIVES        = 3,
  parameter int CLEAR_FRAMES       = 60,
  parameter int INVULN_FRAMES      = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_of_frame,
  input  logic               start_game,
  input  logic               monster_collision,
  input  logic               boss_collision,
  input  logic               asteroid_collision,
  input  logic               player_collision,
  output logic               monster_died_pulse,
  output logic               boss_died_pulse,
  output logic               asteroid_exploded_pulse,
  output logic [STAGE_W-1:0] stage_num,
  output logic [LIVES_W-1:0] lives,
  output logic               boss_active,
  output logic               stage_clear,
  output logic               player_invuln,
  output logic               game_over,
  output logic               game_won
);

  localparam int KW = $clog2(MONSTERS_PER_STAGE + 1);
  localparam int HW = $clog2(BOSS_HP + 1);
  localparam int CW = $clog2(CLEAR_FRAMES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);

  localparam logic [KW-1:0]      KILL_MAX   = KW'(MONSTERS_PER_STAGE);
  localparam logic [HW-1:0]      HP_MAX     = HW'(BOSS_HP);
  localparam logic [CW-1:0]      CLR_LAST   = CW'(CLEAR_FRAMES - 1);
  localparam logic [IW-1:0]      INV_LOAD   = IW'(INVULN_FRAMES);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(MAX_STAGE);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_CAP  = '1;

  state_t             r_state, w_state_nxt;
  logic [STAGE_W-1:0] r_stage;
  logic [LIVES_W-1:0] r_lives, w_lives_nxt;
  logic [KW-1:0]      r_kill_cnt;
  logic [HW-1:0]      r_boss_hp;
  logic [CW-1:0]      r_clear_cnt;
  logic [IW-1:0]      r_invuln_cnt;

  logic w_start, w_mon, w_boss, w_ast, w_ply;
  logic w_in_play, w_in_boss, w_in_clear, w_start_ok;
  logic w_player_hit, w_last_life, w_stage_done, w_clear_done, w_boss_kill, w_grant;

  edge_pulse u_edge_start (.clk(clk), .reset(reset), .i_level(start_game),         .o_rise(w_start));
  edge_pulse u_edge_mon   (.clk(clk), .reset(reset), .i_level(monster_collision),  .o_rise(w_mon));
  edge_pulse u_edge_boss  (.clk(clk), .reset(reset), .i_level(boss_collision),     .o_rise(w_boss));
  edge_pulse u_edge_ast   (.clk(clk), .reset(reset), .i_level(asteroid_collision), .o_rise(w_ast));
  edge_pulse u_edge_ply   (.clk(clk), .reset(reset), .i_level(player_collision),   .o_rise(w_ply));

  assign w_in_play  = (r_state == PLAY);
  assign w_in_boss  = (r_state == BOSS);
  assign w_in_clear = (r_state == STAGE_CLEAR);
  assign w_start_ok = w_start & ((r_state == IDLE) | (r_state == GAME_OVER) | (r_state == WIN));

  assign monster_died_pulse      = w_mon & w_in_play;
  assign asteroid_exploded_pulse = w_ast & (w_in_play | w_in_boss);
  assign w_boss_kill             = w_boss & w_in_boss & (r_boss_hp == HP_MAX - HW'(1));
  // the kill pulse still goes out even if the same cycle ends the game
  assign boss_died_pulse         = w_boss_kill;

  assign w_player_hit = w_ply & (w_in_play | w_in_boss) & (r_invuln_cnt == '0);
  assign w_last_life  = w_player_hit & (r_lives <= LIVES_W'(1));
  assign w_stage_done = monster_died_pulse & (r_kill_cnt == KILL_MAX - KW'(1));
  assign w_clear_done = w_in_clear & start_of_frame & (r_clear_cnt == CLR_LAST);

`ifdef GAME_PROGRESS_EXTRA_LIFE_EN
  logic [5:0] r_total_kills;

  // cumulative kill count across stages; every 16th kill earns a life
  always_ff @(posedge clk) begin
    if (reset || w_start_ok)     r_total_kills <= '0;
    else if (monster_died_pulse) r_total_kills <= r_total_kills + 6'd1;
  end

  assign w_grant = monster_died_pulse & (r_total_kills[3:0] == 4'hF) & ~w_last_life;
`else
  assign w_grant = 1'b0;
`endif

  // next lives value: a hit costs one, a bonus adds one up to the 3-bit ceiling
  always_comb begin
    w_lives_nxt = r_lives;
    if (w_player_hit && r_lives != '0)        w_lives_nxt = r_lives - LIVES_W'(1);
    if (w_grant && w_lives_nxt != LIVES_CAP) w_lives_nxt = w_lives_nxt + LIVES_W'(1);
  end

  // progression FSM; losing the last life overrides any other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, GAME_OVER, WIN: if (w_start_ok)   w_state_nxt = PLAY;
      PLAY:                 if (w_stage_done) w_state_nxt = (r_stage == STAGE_LAST) ? BOSS : STAGE_CLEAR;
      STAGE_CLEAR:          if (w_clear_done) w_state_nxt = PLAY;
      BOSS:                 if (w_boss_kill)  w_state_nxt = WIN;
      default:              w_state_nxt = IDLE;
    endcase
    if (w_last_life) w_state_nxt = GAME_OVER;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // stage, kill, clear-frame and boss-hit counters
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_stage     <= STAGE_W'(1);
      r_kill_cnt  <= '0;
      r_clear_cnt <= '0;
      r_boss_hp   <= '0;
    end else begin
      if (monster_died_pulse && r_kill_cnt != KILL_MAX) r_kill_cnt <= r_kill_cnt + KW'(1);
      if (w_clear_done) begin
        r_clear_cnt <= '0;
        r_kill_cnt  <= '0;
        if (r_stage != STAGE_LAST) r_stage <= r_stage + STAGE_W'(1);
      end else if (w_in_clear && start_of_frame) begin
        r_clear_cnt <= r_clear_cnt + CW'(1);
      end
      if (w_boss && w_in_boss && r_boss_hp != HP_MAX) r_boss_hp <= r_boss_hp + HW'(1);
    end
  end

  // lives and the post-hit invulnerability window (counts frames in any state)
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_lives      <= LIVES_INIT;
      r_invuln_cnt <= '0;
    end else begin
      r_lives <= w_lives_nxt;
      if (w_player_hit)                             r_invuln_cnt <= INV_LOAD;
      else if (start_of_frame && r_invuln_cnt != '0) r_invuln_cnt <= r_invuln_cnt - IW'(1);
    end
  end

  assign stage_num     = r_stage;
  assign lives         = r_lives;
  assign boss_active   = w_in_boss;
  assign stage_clear   = w_in_clear;
  assign player_invuln = (r_invuln_cnt != '0);
  assign game_over     = (r_state == GAME_OVER);
  assign game_won      = (r_state == WIN);

endmodule
